// File: rtl/tcp_test_datagen.sv
// Synthetic 64-bit TCP payload generator: counter/pattern data, rate throttle, block restart, error injection.
// Latency: data_gen high before edge t -> RUN after t+1 -> first o_tx_valid in the cycle after t+2.
// Backpressure: i_tx_afull sampled at the decision edge stalls new beats; one beat may already be in flight.
module tcp_test_datagen #(
  parameter int WIN_BITS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_data_gen,
  input  logic [63:0] i_num_of_data,
  input  logic [7:0]  i_tx_rate,
  input  logic [2:0]  i_word_len,
  input  logic        i_select_seq,
  input  logic [31:0] i_seq_pattern,
  input  logic [23:0] i_blk_size,
  input  logic        i_ins_error_trigger,
  input  logic        i_tx_afull,
  output logic [63:0] o_tx_data,
  output logic [7:0]  o_tx_keep,
  output logic        o_tx_valid,
  output logic        o_busy,
  output logic        o_done,
  output logic [63:0] o_sent_bytes
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIN_BITS-1:0] WIN_ONE = WIN_BITS'(1);

  state_t state;

  // registered copies of the control inputs
  logic        data_gen_q, data_gen_d;
  logic        err_q, err_d;
  logic [63:0] num_q;
  logic [7:0]  rate_q;
  logic [2:0]  word_len_q;
  logic        sel_q;
  logic [31:0] pat_q;
  logic [23:0] blk_q;

  // configuration latched at run start
  logic        unlimited_l;
  logic [7:0]  rate_l;
  logic [2:0]  word_len_l;
  logic        sel_l;
  logic [31:0] pat_l;
  logic        blk_en_l;
  logic [20:0] blk_beats_l;

  // run-time counters
  logic [63:0]         remaining;
  logic [63:0]         word_cnt;
  logic [20:0]         blk_cnt;
  logic [WIN_BITS-1:0] win_cnt;
  logic [WIN_BITS:0]   beat_cnt;
  logic                err_pend;

  logic        start_rise, err_rise;
  logic        credit, emit, last_beat, win_wrap;
  logic [3:0]  beat_bytes;
  logic [7:0]  beat_keep;
  logic [63:0] cnt_beat, beat_dat, words_per_beat;

  assign start_rise = data_gen_q & ~data_gen_d;
  assign err_rise   = err_q & ~err_d;
  assign win_wrap   = &win_cnt;
  assign credit     = (32'(beat_cnt) <= 32'(rate_l));
  assign emit       = (state == S_RUN) && data_gen_q && !i_tx_afull && credit &&
                      (unlimited_l || (remaining != 64'd0));
  assign last_beat  = !unlimited_l && (remaining <= 64'd8);
  assign beat_bytes = (unlimited_l || (remaining >= 64'd8)) ? 4'd8 : remaining[3:0];
  assign beat_keep  = 8'hFF >> (4'd8 - beat_bytes);

  // pack the running counter into one beat according to the word size
  always_comb begin
    cnt_beat       = word_cnt;
    words_per_beat = 64'd1;
    case (word_len_l)
      3'd0: begin
        words_per_beat = 64'd8;
        for (int k = 0; k < 8; k++) cnt_beat[8*k +: 8] = 8'(word_cnt + 64'(k));
      end
      3'd1: begin
        words_per_beat = 64'd4;
        for (int k = 0; k < 4; k++) cnt_beat[16*k +: 16] = 16'(word_cnt + 64'(k));
      end
      3'd2: begin
        words_per_beat = 64'd2;
        for (int k = 0; k < 2; k++) cnt_beat[32*k +: 32] = 32'(word_cnt + 64'(k));
      end
      default: begin
        words_per_beat = 64'd1;
        cnt_beat       = word_cnt;
      end
    endcase
    beat_dat = (sel_l ? {pat_l, pat_l} : cnt_beat) ^ {63'd0, err_pend};
  end

  // input registers and edge-detect history
  always_ff @(posedge CLK) begin
    if (RST) begin
      data_gen_q <= 1'b0;
      data_gen_d <= 1'b0;
      err_q      <= 1'b0;
      err_d      <= 1'b0;
      num_q      <= '0;
      rate_q     <= '0;
      word_len_q <= '0;
      sel_q      <= 1'b0;
      pat_q      <= '0;
      blk_q      <= '0;
    end else begin
      data_gen_q <= i_data_gen;
      data_gen_d <= data_gen_q;
      err_q      <= i_ins_error_trigger;
      err_d      <= err_q;
      num_q      <= i_num_of_data;
      rate_q     <= i_tx_rate;
      word_len_q <= i_word_len;
      sel_q      <= i_select_seq;
      pat_q      <= i_seq_pattern;
      blk_q      <= i_blk_size;
    end
  end

  // run FSM, beat generation, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      o_tx_data    <= '0;
      o_tx_keep    <= '0;
      o_tx_valid   <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_sent_bytes <= '0;
      unlimited_l  <= 1'b0;
      rate_l       <= '0;
      word_len_l   <= '0;
      sel_l        <= 1'b0;
      pat_l        <= '0;
      blk_en_l     <= 1'b0;
      blk_beats_l  <= '0;
      remaining    <= '0;
      word_cnt     <= '0;
      blk_cnt      <= '0;
      win_cnt      <= '0;
      beat_cnt     <= '0;
      err_pend     <= 1'b0;
    end else begin
      o_tx_valid <= 1'b0;
      o_done     <= 1'b0;
      // a new edge re-arms even if this cycle's beat consumes the old flag
      err_pend   <= err_rise | (err_pend & ~emit);

      if (emit) begin
        o_tx_valid   <= 1'b1;
        o_tx_data    <= beat_dat;
        o_tx_keep    <= beat_keep;
        o_sent_bytes <= o_sent_bytes + 64'(beat_bytes);
        if (!unlimited_l) remaining <= remaining - 64'(beat_bytes);
        if (blk_en_l && ((blk_cnt + 21'd1) == blk_beats_l)) begin
          word_cnt <= '0;
          blk_cnt  <= '0;
        end else begin
          word_cnt <= word_cnt + words_per_beat;
          blk_cnt  <= blk_cnt + 21'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start_rise) begin
            unlimited_l  <= (num_q == 64'd0);
            remaining    <= num_q;
            rate_l       <= rate_q;
            word_len_l   <= word_len_q;
            sel_l        <= sel_q;
            pat_l        <= pat_q;
            blk_en_l     <= (blk_q >= 24'd8);
            blk_beats_l  <= blk_q[23:3];
            o_sent_bytes <= '0;
            word_cnt     <= '0;
            blk_cnt      <= '0;
            win_cnt      <= '0;
            beat_cnt     <= '0;
            o_busy       <= 1'b1;
            state        <= S_RUN;
          end
        end
        S_RUN: begin
          win_cnt  <= win_cnt + WIN_ONE;
          beat_cnt <= win_wrap ? '0 : beat_cnt + (WIN_BITS+1)'(emit);
          if (!data_gen_q) begin
            o_busy <= 1'b0;
            state  <= S_IDLE;
          end else if (emit && last_beat) begin
            o_busy <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          o_done <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_test_datagen.sv
module tb_tcp_test_datagen;

  logic        CLK = 1'b0;
  logic        RST;
  logic        i_data_gen;
  logic [63:0] i_num_of_data;
  logic [7:0]  i_tx_rate;
  logic [2:0]  i_word_len;
  logic        i_select_seq;
  logic [31:0] i_seq_pattern;
  logic [23:0] i_blk_size;
  logic        i_ins_error_trigger;
  logic        i_tx_afull;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_keep;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_done;
  logic [63:0] o_sent_bytes;

  tcp_test_datagen #(.WIN_BITS(8)) dut (
    .CLK(CLK), .RST(RST),
    .i_data_gen(i_data_gen), .i_num_of_data(i_num_of_data), .i_tx_rate(i_tx_rate),
    .i_word_len(i_word_len), .i_select_seq(i_select_seq), .i_seq_pattern(i_seq_pattern),
    .i_blk_size(i_blk_size), .i_ins_error_trigger(i_ins_error_trigger), .i_tx_afull(i_tx_afull),
    .o_tx_data(o_tx_data), .o_tx_keep(o_tx_keep), .o_tx_valid(o_tx_valid),
    .o_busy(o_busy), .o_done(o_done), .o_sent_bytes(o_sent_bytes)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int c0 = 0;
  int done_cnt = 0;
  logic [63:0] q_dat[$];
  logic [7:0]  q_keep[$];
  int          q_cyc[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // beat and done capture, sampled on the falling edge
  always @(negedge CLK) begin
    if (o_tx_valid) begin
      q_dat.push_back(o_tx_data);
      q_keep.push_back(o_tx_keep);
      q_cyc.push_back(cyc);
    end
    if (o_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #2;
  endtask

  task automatic start_run(input logic [2:0] wl, input logic sel, input logic [31:0] pat,
                           input logic [63:0] num, input logic [7:0] rate, input logic [23:0] blk);
    i_data_gen = 1'b0;
    tick(3);
    q_dat.delete(); q_keep.delete(); q_cyc.delete();
    done_cnt      = 0;
    i_word_len    = wl;
    i_select_seq  = sel;
    i_seq_pattern = pat;
    i_num_of_data = num;
    i_tx_rate     = rate;
    i_blk_size    = blk;
    i_data_gen    = 1'b1;
    c0            = cyc;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk("done_seen", 64'(done_cnt), 64'd1);
  endtask

  task automatic pulse_err();
    i_ins_error_trigger = 1'b1;
    tick(1);
    i_ins_error_trigger = 1'b0;
  endtask

  initial begin
    int n0, n, errs;
    logic [63:0] bad;
    RST = 1'b1; i_data_gen = 1'b0; i_num_of_data = '0; i_tx_rate = '0; i_word_len = '0;
    i_select_seq = 1'b0; i_seq_pattern = '0; i_blk_size = '0; i_ins_error_trigger = 1'b0;
    i_tx_afull = 1'b0;
    tick(3);
    chk("rst_data", o_tx_data, 64'd0);
    chk("rst_keep", 64'(o_tx_keep), 64'd0);
    chk("rst_valid", 64'(o_tx_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_sent", o_sent_bytes, 64'd0);
    RST = 1'b0;
    tick(2);

    // 8-byte counter, 32 bytes, full rate
    start_run(3'd3, 1'b0, 32'd0, 64'd32, 8'd255, 24'd0);
    tick(2);
    chk("A_busy_run", 64'(o_busy), 64'd1);
    wait_done(50);
    chk("A_busy_fall", 64'(o_busy), 64'd0);
    chk("A_nbeats", 64'(q_dat.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("A_data", q_dat[i], 64'(i));
      chk("A_keep", 64'(q_keep[i]), 64'hFF);
    end
    chk("A_latency", 64'(q_cyc[0] - c0), 64'd3);
    chk("A_back2back", 64'(q_cyc[3] - q_cyc[0]), 64'd3);
    chk("A_sent", o_sent_bytes, 64'd32);
    tick(1);
    chk("A_done_1cyc", 64'(o_done), 64'd0);

    // byte counter, 12 bytes -> partial last beat
    start_run(3'd0, 1'b0, 32'd0, 64'd12, 8'd255, 24'd0);
    wait_done(50);
    chk("B_nbeats", 64'(q_dat.size()), 64'd2);
    chk("B_data0", q_dat[0], 64'h0706050403020100);
    chk("B_keep0", 64'(q_keep[0]), 64'hFF);
    chk("B_data1", q_dat[1], 64'h0F0E0D0C0B0A0908);
    chk("B_keep1", 64'(q_keep[1]), 64'h0F);
    chk("B_sent", o_sent_bytes, 64'd12);

    // 32-bit counter words
    start_run(3'd2, 1'b0, 32'd0, 64'd16, 8'd255, 24'd0);
    wait_done(50);
    chk("W_data0", q_dat[0], 64'h0000000100000000);
    chk("W_data1", q_dat[1], 64'h0000000300000002);

    // fixed pattern
    start_run(3'd3, 1'b1, 32'hDEADBEEF, 64'd16, 8'd255, 24'd0);
    wait_done(50);
    chk("C_nbeats", 64'(q_dat.size()), 64'd2);
    chk("C_data0", q_dat[0], 64'hDEADBEEFDEADBEEF);
    chk("C_data1", q_dat[1], 64'hDEADBEEFDEADBEEF);

    // 16-byte blocks restart the counter every two beats
    start_run(3'd3, 1'b0, 32'd0, 64'd48, 8'd255, 24'd16);
    wait_done(50);
    chk("D_nbeats", 64'(q_dat.size()), 64'd6);
    for (int i = 0; i < 6; i++) chk("D_data", q_dat[i], 64'(i % 2));

    // unlimited at minimum rate, then afull hold, then abort
    start_run(3'd3, 1'b0, 32'd0, 64'd0, 8'd0, 24'd0);
    tick(700);
    chk("E_nbeats", 64'(q_dat.size()), 64'd3);
    chk("E_gap1", 64'(q_cyc[1] - q_cyc[0]), 64'd256);
    chk("E_gap2", 64'(q_cyc[2] - q_cyc[1]), 64'd256);
    chk("E_data2", q_dat[2], 64'd2);
    i_tx_afull = 1'b1;
    n0 = q_dat.size();
    tick(1000);
    chk("E_afull_le1", 64'(q_dat.size() - n0 <= 1), 64'd1);
    n0 = q_dat.size();
    i_tx_afull = 1'b0;
    n = 0;
    while (q_dat.size() == n0 && n < 300) begin
      tick(1);
      n++;
    end
    chk("E_resume", 64'(q_dat.size() > n0), 64'd1);
    i_data_gen = 1'b0;
    tick(3);
    chk("E_abort_busy", 64'(o_busy), 64'd0);
    chk("E_abort_nodone", 64'(done_cnt), 64'd0);
    chk("E_abort_sent", o_sent_bytes, 64'(8 * q_dat.size()));

    // single error injection mid-run
    start_run(3'd3, 1'b0, 32'd0, 64'd64, 8'd255, 24'd0);
    tick(3);
    pulse_err();
    wait_done(50);
    chk("F_nbeats", 64'(q_dat.size()), 64'd8);
    errs = 0;
    bad  = 64'd0;
    for (int i = 0; i < q_dat.size(); i++) begin
      if (q_dat[i] !== 64'(i)) begin
        errs++;
        bad = q_dat[i] ^ 64'(i);
      end
    end
    chk("F_one_err", 64'(errs), 64'd1);
    chk("F_err_bit0", bad, 64'd1);
    chk("F_sent", o_sent_bytes, 64'd64);

    // flag raised while idle corrupts the first beat of the next run
    pulse_err();
    tick(3);
    start_run(3'd3, 1'b0, 32'd0, 64'd16, 8'd255, 24'd0);
    wait_done(50);
    chk("P_data0", q_dat[0], 64'd1);
    chk("P_data1", q_dat[1], 64'd1);

    // reset mid-run clears outputs and the pending flag
    start_run(3'd3, 1'b0, 32'd0, 64'd0, 8'd255, 24'd0);
    tick(8);
    i_tx_afull = 1'b1;
    pulse_err();
    tick(3);
    RST = 1'b1;
    i_data_gen = 1'b0;
    tick(1);
    chk("G_rst_valid", 64'(o_tx_valid), 64'd0);
    chk("G_rst_busy", 64'(o_busy), 64'd0);
    chk("G_rst_data", o_tx_data, 64'd0);
    chk("G_rst_keep", 64'(o_tx_keep), 64'd0);
    chk("G_rst_sent", o_sent_bytes, 64'd0);
    RST = 1'b0;
    i_tx_afull = 1'b0;
    tick(2);
    start_run(3'd3, 1'b0, 32'd0, 64'd16, 8'd255, 24'd0);
    wait_done(50);
    chk("G_data0", q_dat[0], 64'd0);
    chk("G_data1", q_dat[1], 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
